uart_host_ctrl: RTL

//  Bus initiator for the uart_regs register interface: drives its 8-bit we/re register port
//  so that a streaming core can use the UART without CPU firmware.

---
 rtl/uart_host_ctrl.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl
//   Register-bus initiator that runs a uart_regs-style UART without firmware.
//   After reset it programs the divisor latch, LCR, FCR, IER and MCR. It then
//   loops for ever: it polls LSR, drains RBR into an RX stream and feeds a TX
//   stream into THR.
//
// Ports
//   clk          system clock
//   wb_rst_ni    asynchronous active-low reset
//   wb_addr_o    register address (0 RB/TR, 1 IE, 2 II/FC, 3 LC, 4 MC, 5 LS)
//   wb_dat_o     write data
//   wb_dat_i     read data, combinational from the UART during wb_re_o
//   wb_we_o      write strobe
//   wb_re_o      read strobe
//   tx_data      byte to transmit
//   tx_valid     tx_data valid
//   tx_ready     byte consumed this cycle
//   rx_data      received byte
//   rx_valid     rx_data valid, held until accepted
//   rx_ready     consumer accepts rx_data
//   err_o        sticky LSR[4:1] = {BI,FE,PE,OE}
//   err_clr_i    clears err_o (a coincident LSR sample wins)
//   init_done    high once configuration is complete
//   dbg_state_o  current FSM state, for observation only
//
// Handshakes: a stream byte moves on any clock edge where valid && ready are
// both high. The producer holds valid and data stable until that edge.
// tx_ready is high only in a THR write strobe cycle. rx_valid stays high
// until the cycle after rx_valid && rx_ready.
//
// Bus accesses always take two cycles: one strobe cycle with exactly one of
// we/re high, then one gap cycle with both low. Address and data are zero
// outside strobe cycles.

module uart_host_ctrl #(
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_INIT = 8'h03,
    parameter logic [7:0]  FCR_INIT = 8'hC6,
    parameter logic [7:0]  IER_INIT = 8'h00,
    parameter logic [7:0]  MCR_INIT = 8'h00,
    parameter int unsigned TX_BURST = 1
) (
    input  logic       clk,
    input  logic       wb_rst_ni,
    output logic [2:0] wb_addr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_re_o,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [3:0] err_o,
    input  logic       err_clr_i,
    output logic       init_done,
    output logic [3:0] dbg_state_o
);

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_INIT_STB = 4'd1,
        S_INIT_GAP = 4'd2,
        S_POLL_STB = 4'd3,
        S_POLL_GAP = 4'd4,
        S_RX_STB   = 4'd5,
        S_RX_GAP   = 4'd6,
        S_TX_STB   = 4'd7,
        S_TX_GAP   = 4'd8
    } state_e;

    localparam logic [2:0] ADDR_RBTR = 3'd0;
    localparam logic [2:0] ADDR_LSR  = 3'd5;
    localparam logic [2:0] INIT_LAST = 3'd6;
    localparam logic [4:0] BURST_MAX = 5'(TX_BURST);
    localparam logic [7:0] LCR_BASE  = LCR_INIT & 8'h7F;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;          // INIT table position
    logic       rx_avail_q, rx_avail_d; // LSR[0] from the last poll
    logic       thre_q, thre_d;         // LSR[5] from the last poll
    logic [4:0] burst_q, burst_d;       // THR writes since the last LSR read
    logic       last_tx_q, last_tx_d;   // side served last; resets to TX so RX wins the first tie
    logic [2:0] addr_q, addr_d;
    logic [7:0] dat_q, dat_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       tx_ready_q, tx_ready_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [3:0] err_q, err_d;
    logic       init_done_q, init_done_d;

    logic rx_elig;
    logic tx_elig;
    logic serve_rx;
    logic serve_tx;

    // Configuration writes in order: {addr, data}.
    function automatic logic [10:0] init_entry(input logic [2:0] i);
        logic [10:0] e;
        case (i)
            3'd0:    e = {3'd3, LCR_BASE | 8'h80};
            3'd1:    e = {3'd0, DIVISOR[7:0]};
            3'd2:    e = {3'd1, DIVISOR[15:8]};
            3'd3:    e = {3'd3, LCR_BASE};
            3'd4:    e = {3'd2, FCR_INIT};
            3'd5:    e = {3'd1, IER_INIT};
            default: e = {3'd4, MCR_INIT};
        endcase
        return e;
    endfunction

    assign rx_elig  = rx_avail_q && !rx_valid_q;
    assign tx_elig  = thre_q && tx_valid;
    assign serve_rx = rx_elig && (!tx_elig || last_tx_q);
    assign serve_tx = tx_elig && !serve_rx;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rx_avail_d  = rx_avail_q;
        thre_d      = thre_q;
        burst_d     = burst_q;
        last_tx_d   = last_tx_q;
        addr_d      = 3'd0;
        dat_d       = 8'h00;
        we_d        = 1'b0;
        re_d        = 1'b0;
        tx_ready_d  = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        err_d       = err_q;
        init_done_d = init_done_q;

        if (err_clr_i) begin
            err_d = 4'd0;
        end
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_START: begin
                {addr_d, dat_d} = init_entry(3'd0);
                we_d    = 1'b1;
                idx_d   = 3'd0;
                state_d = S_INIT_STB;
            end
            S_INIT_STB: state_d = S_INIT_GAP;
            S_INIT_GAP: begin
                if (idx_q == INIT_LAST) begin
                    init_done_d = 1'b1;
                    addr_d      = ADDR_LSR;
                    re_d        = 1'b1;
                    state_d     = S_POLL_STB;
                end else begin
                    idx_d           = idx_q + 3'd1;
                    {addr_d, dat_d} = init_entry(idx_q + 3'd1);
                    we_d            = 1'b1;
                    state_d         = S_INIT_STB;
                end
            end
            S_POLL_STB: begin
                // New error bits are ORed after a possible clear: set wins.
                rx_avail_d = wb_dat_i[0];
                thre_d     = wb_dat_i[5];
                err_d      = err_d | wb_dat_i[4:1];
                burst_d    = 5'd0;
                state_d    = S_POLL_GAP;
            end
            S_POLL_GAP: begin
                if (serve_rx) begin
                    addr_d    = ADDR_RBTR;
                    re_d      = 1'b1;
                    last_tx_d = 1'b0;
                    state_d   = S_RX_STB;
                end else if (serve_tx) begin
                    addr_d     = ADDR_RBTR;
                    dat_d      = tx_data;
                    we_d       = 1'b1;
                    tx_ready_d = 1'b1;
                    burst_d    = burst_q + 5'd1;
                    last_tx_d  = 1'b1;
                    state_d    = S_TX_STB;
                end else begin
                    addr_d  = ADDR_LSR;
                    re_d    = 1'b1;
                    state_d = S_POLL_STB;
                end
            end
            S_RX_STB: begin
                rx_data_d  = wb_dat_i;
                rx_valid_d = 1'b1;
                state_d    = S_RX_GAP;
            end
            S_RX_GAP: begin
                addr_d  = ADDR_LSR;
                re_d    = 1'b1;
                state_d = S_POLL_STB;
            end
            S_TX_STB: state_d = S_TX_GAP;
            S_TX_GAP: begin
                // THRE was seen once for this burst; the FIFO depth bounds
                // how many more bytes may follow without another LSR read.
                if (tx_valid && (burst_q < BURST_MAX)) begin
                    addr_d     = ADDR_RBTR;
                    dat_d      = tx_data;
                    we_d       = 1'b1;
                    tx_ready_d = 1'b1;
                    burst_d    = burst_q + 5'd1;
                    state_d    = S_TX_STB;
                end else begin
                    addr_d  = ADDR_LSR;
                    re_d    = 1'b1;
                    state_d = S_POLL_STB;
                end
            end
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_START;
            idx_q       <= 3'd0;
            rx_avail_q  <= 1'b0;
            thre_q      <= 1'b0;
            burst_q     <= 5'd0;
            last_tx_q   <= 1'b1;
            addr_q      <= 3'd0;
            dat_q       <= 8'h00;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            err_q       <= 4'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rx_avail_q  <= rx_avail_d;
            thre_q      <= thre_d;
            burst_q     <= burst_d;
            last_tx_q   <= last_tx_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            re_q        <= re_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            err_q       <= err_d;
            init_done_q <= init_done_d;
        end
    end

    assign wb_addr_o   = addr_q;
    assign wb_dat_o    = dat_q;
    assign wb_we_o     = we_q;
    assign wb_re_o     = re_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign err_o       = err_q;
    assign init_done   = init_done_q;
    assign dbg_state_o = state_q;

endmodule
